// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port between the pixel reader (master) and the double-buffered RAM (slave).
interface vga_frame_reader_if #(
    parameter int ADDR_W = 18
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_frame_reader.sv
// 2x-upscaling grayscale frame reader with frame-boundary bank swap and a colour-bar
// test pattern until the first swap; sync strobes are delay-matched to the 3-stage pipe.
module vga_frame_reader #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int ADDR_W    = 18,
    parameter int SWAP_LINE = 480
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic [9:0]         hs,
    input  logic [9:0]         vs,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               blank_in,
    vga_frame_reader_if.master mem,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               disp_bank,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank_n,
    output logic               vga_sync_n
);
    localparam int IDX_W = ADDR_W - 1;

    typedef enum logic {S_TEST = 1'b0, S_SHOW = 1'b1} state_t;

    typedef struct packed {
        logic [2:0] bar;
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       show;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{bar: 3'd0, hsync: 1'b1, vsync: 1'b1, active: 1'b0, show: 1'b0};

    state_t state_q;
    logic   bank_q;
    logic   ack_q;
    logic   boundary;

    assign boundary = (hs == 10'd0) && (vs == 10'(SWAP_LINE));

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state_q <= S_TEST;
            bank_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_TEST: begin
                    if (boundary && swap_req) begin
                        bank_q  <= ~bank_q;
                        ack_q   <= 1'b1;
                        state_q <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (boundary && swap_req) begin
                        bank_q <= ~bank_q;
                        ack_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage 1: address generation; mode and bank are captured here and ride with the pixel.
    logic              in_img;
    logic              fetch;
    logic [IDX_W-1:0]  idx;
    logic              rd_en_d, rd_en_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    stage_t            s1_d, s1_q, s2_d, s2_q;

    always_comb begin
        in_img  = ((vs >> 1) < 10'(IMG_H)) && ((hs >> 1) < 10'(IMG_W));
        idx     = IDX_W'(vs[8:1]) * IDX_W'(IMG_W) + IDX_W'(hs[9:1]);
        fetch   = blank_in && in_img && (state_q == S_SHOW);
        rd_en_d = fetch;
        addr_d  = fetch ? {bank_q, idx} : '0;

        s1_d        = STAGE_IDLE;
        s1_d.bar    = hs[9:7];
        s1_d.hsync  = hsync_in;
        s1_d.vsync  = vsync_in;
        s1_d.active = blank_in;
        s1_d.show   = (state_q == S_SHOW);

        s2_d = s1_q;
    end

    // Stage 3: RAM word for image mode, one bar bit per channel for test mode.
    logic [2:0][7:0] rgb_d, rgb_q;
    logic            hsync_d, hsync_q;
    logic            vsync_d, vsync_q;
    logic            blank_n_d, blank_n_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_d[gi] = !s2_q.active ? 8'h00 :
                               s2_q.show    ? mem.mem_rdata : {8{s2_q.bar[gi]}};
        end
    endgenerate

    always_comb begin
        hsync_d   = s2_q.hsync;
        vsync_d   = s2_q.vsync;
        blank_n_d = s2_q.active;
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            s1_q      <= STAGE_IDLE;
            s2_q      <= STAGE_IDLE;
            rgb_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign mem.mem_rd_en = rd_en_q;
    assign mem.mem_addr  = addr_q;
    assign swap_ack      = ack_q;
    assign disp_bank     = bank_q;
    assign vga_r         = rgb_q[2];
    assign vga_g         = rgb_q[1];
    assign vga_b         = rgb_q[0];
    assign vga_hsync     = hsync_q;
    assign vga_vsync     = vsync_q;
    assign vga_blank_n   = blank_n_q;
    assign vga_sync_n    = hsync_q & vsync_q;
endmodule
